// File: rtl/rx_alu_pkg.sv
// rx_alu_pkg: shared widths and one-hot FSM state encodings for the UART/ALU front end
package rx_alu_pkg;
  localparam int RX_DBIT = 8;
  localparam int RX_OPW = 6;
  localparam logic [5:0] S_WAIT_A  = 6'b000001;
  localparam logic [5:0] S_WAIT_B  = 6'b000010;
  localparam logic [5:0] S_WAIT_OP = 6'b000100;
  localparam logic [5:0] S_EXEC    = 6'b001000;
  localparam logic [5:0] S_SEND    = 6'b010000;
  localparam logic [5:0] S_WAIT_TX = 6'b100000;
endpackage

// File: rtl/rx_alu_frontend_interbyte_timer.sv
// interbyte_timer: counts idle cycles while enabled, pulses expire on the last cycle and restarts
module interbyte_timer #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expire = en && !clr && (cnt == CW'(CYCLES - 1));
  // count only while enabled; any byte, expiry or leaving the wait states restarts from 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (!en || clr || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rx_alu_frontend.sv
// rx_alu_frontend: assembles A/B/opcode frames from the receiver, captures the ALU result and starts
// the transmitter; the inter-byte timeout is built only when RX_ALU_FRONTEND_TIMEOUT_EN is defined
module rx_alu_frontend
  import rx_alu_pkg::*;
#(
  parameter int DBIT = RX_DBIT,
  parameter int OPW = RX_OPW,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] rx_data,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [DBIT-1:0] op_a,
  output logic [DBIT-1:0] op_b,
  output logic [OPW-1:0]  op_code,
  output logic [DBIT-1:0] tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            overrun,
  output logic            timeout
);
  logic [5:0] state;
  logic expire;
`ifdef RX_ALU_FRONTEND_TIMEOUT_EN
  interbyte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .en(state == S_WAIT_B || state == S_WAIT_OP),
    .clr(rx_done_tick),
    .expire(expire)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  assign busy = |(state & (S_EXEC | S_SEND | S_WAIT_TX));
  // frame assembly FSM; each state consumes at most one rx pulse so a byte never advances two states
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_WAIT_A;
      op_a <= '0;
      op_b <= '0;
      op_code <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      tx_start <= (state == S_EXEC);
      timeout <= expire;
      if (rx_done_tick && busy) overrun <= 1'b1;
      case (state)
        S_WAIT_A: if (rx_done_tick) begin
          op_a <= rx_data;
          state <= S_WAIT_B;
        end
        S_WAIT_B: if (rx_done_tick) begin
          op_b <= rx_data;
          state <= S_WAIT_OP;
        end else if (expire) state <= S_WAIT_A;
        S_WAIT_OP: if (rx_done_tick) begin
          op_code <= rx_data[OPW-1:0];
          state <= S_EXEC;
        end else if (expire) state <= S_WAIT_A;
        S_EXEC: begin
          tx_data <= alu_result;
          state <= S_SEND;
        end
        S_SEND: state <= S_WAIT_TX;
        S_WAIT_TX: if (tx_done_tick) state <= S_WAIT_A;
        default: state <= S_WAIT_A;
      endcase
    end
endmodule

// File: tb/tb_rx_alu_frontend.sv
// tb_rx_alu_frontend: directed frames against a small ADD-only ALU model
module tb_rx_alu_frontend;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_done_tick = 1'b0;
  logic [7:0] alu_result;
  logic tx_done_tick = 1'b0;
  logic [7:0] op_a, op_b, tx_data;
  logic [5:0] op_code;
  logic tx_start, busy, overrun, timeout;
  int checks = 0;
  int failures = 0;
  int starts = 0;
  int touts = 0;

  rx_alu_frontend #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .alu_result(alu_result), .tx_done_tick(tx_done_tick), .op_a(op_a), .op_b(op_b),
    .op_code(op_code), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  assign alu_result = (op_code == 6'h20) ? op_a + op_b : 8'h00;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) starts++;
    if (timeout) touts++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data = '0;
  endtask

  task automatic tx_done();
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] exp);
    check({tag, ".exec_busy"}, busy, 1);
    check({tag, ".exec_start"}, tx_start, 0);
    @(negedge clk);
    check({tag, ".start"}, tx_start, 1);
    check({tag, ".tx_data"}, tx_data, exp);
    @(negedge clk);
    check({tag, ".start_low"}, tx_start, 0);
    check({tag, ".wait_busy"}, busy, 1);
  endtask

  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [7:0] exp);
    rx(a);
    rx(b);
    rx(op);
    check({tag, ".op_a"}, op_a, a);
    check({tag, ".op_b"}, op_b, b);
    check({tag, ".op_code"}, op_code, op[5:0]);
    expect_result(tag, exp);
    repeat (3) @(negedge clk);
    check({tag, ".hold_busy"}, busy, 1);
    tx_done();
    check({tag, ".idle"}, busy, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".op_a"}, op_a, 0);
    check({tag, ".op_b"}, op_b, 0);
    check({tag, ".op_code"}, op_code, 0);
    check({tag, ".tx_data"}, tx_data, 0);
    check({tag, ".tx_start"}, tx_start, 0);
    check({tag, ".overrun"}, overrun, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    frame("basic", 8'h05, 8'h03, 8'h20, 8'h08);
    check("basic.starts", starts, 1);
    frame("b2b", 8'hFF, 8'h01, 8'h20, 8'h00);
    check("b2b.starts", starts, 2);
    rx(8'h10);
    rx(8'h20);
    rx(8'h20);
    expect_result("ovr", 8'h30);
    rx(8'hAA);
    check("ovr.flag", overrun, 1);
    check("ovr.op_a_kept", op_a, 8'h10);
    tx_done();
    frame("ovr_next", 8'h04, 8'h05, 8'h20, 8'h09);
    check("ovr.sticky", overrun, 1);
    check("ovr.starts", starts, 4);
    rx(8'h30);
    tx_done();
    repeat (3) @(negedge clk);
    check("spur.busy", busy, 0);
    check("spur.starts", starts, 4);
    rx(8'h40);
    rx(8'h20);
    check("spur.op_a", op_a, 8'h30);
    check("spur.op_b", op_b, 8'h40);
    expect_result("spur", 8'h70);
    tx_done();
    rx(8'h11);
    rx(8'h22);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midrst");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst.no_start", starts, 5);
    check("midrst.idle", busy, 0);
    frame("midrst_next", 8'h01, 8'h02, 8'h20, 8'h03);
    check("midrst.starts", starts, 6);
`ifdef RX_ALU_FRONTEND_TIMEOUT_EN
    rx(8'h07);
    repeat (12) @(negedge clk);
    check("tout.pulses", touts, 1);
    check("tout.idle", busy, 0);
    check("tout.op_a_kept", op_a, 8'h07);
    frame("tout_next", 8'h02, 8'h03, 8'h20, 8'h05);
`else
    rx(8'h07);
    repeat (20) @(negedge clk);
    check("notout.pulses", touts, 0);
    rx(8'h03);
    rx(8'h20);
    check("notout.op_a", op_a, 8'h07);
    check("notout.op_b", op_b, 8'h03);
    expect_result("notout", 8'h0A);
    tx_done();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_alu_frontend.md
Name: rx_alu_frontend

Overview:
Consumes the UART receiver's parallel output (data byte plus one-clk done pulse) and assembles three-byte command frames: operand A, operand B, opcode. Drives the combinational ALU with the latched operands and captures its result. Hands the result to the UART transmitter with a start/done handshake. Sits between the receiver and the transmitter/ALU pair in the top level.

Parameters:
DBIT, 8, data/operand/result width in bits (matches the receiver's DBIT)
OPW, 6, opcode width; the opcode is the low OPW bits of the third byte
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  DBIT  received byte; valid only while rx_done_tick=1
rx_done_tick  in  1  one-clk pulse from the receiver, one per byte
alu_result  in  DBIT  combinational ALU output for op_a/op_b/op_code
tx_done_tick  in  1  one-clk pulse from the transmitter when the byte has been sent
op_a  out  DBIT  latched operand A to the ALU
op_b  out  DBIT  latched operand B to the ALU
op_code  out  OPW  latched opcode to the ALU
tx_data  out  DBIT  result byte to the transmitter
tx_start  out  1  one-clk start pulse to the transmitter
busy  out  1  high in EXEC, SEND and WAIT_TX
overrun  out  1  sticky flag: a byte arrived while busy and was dropped
timeout  out  1  one-clk pulse on inter-byte timeout; tied 0 without the feature

Behaviour:
- Reset is asynchronous, active-low. It clears op_a, op_b, op_code, tx_data, tx_start, overrun and timeout to 0 and sets the state to WAIT_A.
- The FSM is one-hot with six states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. All outputs are registered.
- WAIT_A: on rx_done_tick, op_a <= rx_data and go to WAIT_B.
- WAIT_B: on rx_done_tick, op_b <= rx_data and go to WAIT_OP.
- WAIT_OP: on rx_done_tick, op_code <= rx_data[OPW-1:0] and go to EXEC.
- EXEC: lasts exactly one cycle. tx_data <= alu_result (operands are stable for a full cycle), then go to SEND.
- SEND: tx_start=1 for exactly this one cycle, then go to WAIT_TX.
- WAIT_TX: on tx_done_tick, go to WAIT_A. There is no limit on the wait.
- Latency:
  - Opcode rx_done_tick edge to tx_start high is 2 clks: the opcode is captured at edge N, tx_data at N+1, and tx_start is high during the cycle after N+1.
  - tx_done_tick to ready for the next A is 1 clk.
- rx_done_tick while busy: the byte is dropped and overrun <= 1. overrun is cleared only by reset.
- tx_done_tick outside WAIT_TX is ignored.
- op_a, op_b and op_code hold their values until overwritten by the next frame. The ALU output therefore stays stable while a new frame is partially received.
- An rx_done_tick that coincides with a state change is consumed by the current state only; a single pulse never advances two states.
- Reset asserted mid-frame or mid-transmit aborts the frame. No tx_start is issued after reset deasserts until a full new frame is received.

Optional Feature:
Macro RX_ALU_FRONTEND_TIMEOUT_EN.
- Defined:
  - In WAIT_B and WAIT_OP, a counter increments each clk and clears on every accepted rx_done_tick.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the state returns to WAIT_A, timeout pulses for 1 clk and the counter clears. Partial operands stay latched.
  - The counter is held at 0 in all other states.
- Undefined: no counter is built, timeout is constant 0, and a partial frame waits indefinitely.

Decomposition:
- Shared package rx_alu_pkg holds:
  - the one-hot state encoding constants (6 bits);
  - the OPW default;
  - the DBIT default, shared with the receiver and transmitter.
- One sub-module is natural: interbyte_timer, which contains the counter, clear/enable and expiry pulse. It is instantiated only under RX_ALU_FRONTEND_TIMEOUT_EN.

Test Plan:
- Basic frame: after reset, bytes 0x05, 0x03, 0x20 with the ALU modelled as ADD=0x20. Expect op_a=0x05, op_b=0x03, op_code=6'h20. tx_data=0x08 and tx_start is one clk high 2 clks after the third tick. busy stays high until tx_done_tick, then the state is WAIT_A.
- Back-to-back frames: a second frame 0xFF, 0x01, 0x20 sent after tx_done_tick gives tx_data=0x00 (wrap in the ALU model) and exactly one tx_start per frame.
- Overrun: inject rx_done_tick with 0xAA during WAIT_TX. Expect overrun=1, op_a unchanged, and the next frame still processed correctly with overrun remaining 1.
- Reset mid-frame: send 0x11 and 0x22, assert reset low for 3 clks, then send 0x01, 0x02, 0x20. Expect all outputs 0 during reset, then tx_data=0x03 with no spurious tx_start.
- Spurious tx_done_tick: a pulse in WAIT_B causes no state change and no tx_start.
- Timeout (macro defined, TIMEOUT_CYCLES=10): send 0x07, then idle 10 clks. Expect a timeout pulse and state WAIT_A. The next bytes 0x02, 0x03, 0x20 yield tx_data=0x05.
